// File: rtl/alt_eyemon_ir_arbiter.sv
// ---------------------------------------------------------------------------
// alt_eyemon_ir_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter in front of the eye-monitor Avalon-MM
//   master's internal-register (IR) port. Requester 0 is the JTAG/CSR slave,
//   requester 1 is the auto-sweep sequencer. A granted request is latched,
//   started with a 1-cycle o_ir_trigger, and held stable on o_ir_* until the
//   master answers with i_ir_done. The result goes back to the owner as a
//   1-cycle o_rN_done pulse. A watchdog flags a transaction stuck in WAIT.
//
// Handshake:
//   A requester raises i_rN_req with its fields valid and keeps both stable
//   until it samples o_rN_done high, then drops the request. o_rN_done acts
//   as the one-cycle "accepted and complete" response; there is no separate
//   ready. On the IR side, o_ir_trigger starts one transaction and
//   i_ir_done (qualified only in WAIT) completes it.
//
// Ports:
//   i_avmm_clk, i_resetn          clock, synchronous active-low reset
//   i_rN_req/chaddress/wdaddress/writedata/rwn   requester N (N=0,1)
//   o_rN_done, o_rN_readdata      completion pulse and read result to N
//   o_ir_trigger, o_ir_*          start pulse and latched transaction fields
//   i_ir_done, i_ir_readdata      completion and read data from the master
//   o_grant                       one-hot owner, 0 when idle
//   o_busy                        high whenever the FSM is not idle
//   o_timeout, i_clr_timeout      sticky watchdog flag and its clear
//   o_state                       current FSM state for observation
// ---------------------------------------------------------------------------
module alt_eyemon_ir_arbiter #(
    parameter int IREG_CHADDR_WIDTH = 16,
    parameter int IREG_WDADDR_WIDTH = 16,
    parameter int IREG_DATA_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES    = 1024,
    parameter int TIMEOUT_W         = 11
) (
    input  logic                         i_avmm_clk,
    input  logic                         i_resetn,

    input  logic                         i_r0_req,
    input  logic [IREG_CHADDR_WIDTH-1:0] i_r0_chaddress,
    input  logic [IREG_WDADDR_WIDTH-1:0] i_r0_wdaddress,
    input  logic [IREG_DATA_WIDTH-1:0]   i_r0_writedata,
    input  logic                         i_r0_rwn,
    output logic                         o_r0_done,
    output logic [IREG_DATA_WIDTH-1:0]   o_r0_readdata,

    input  logic                         i_r1_req,
    input  logic [IREG_CHADDR_WIDTH-1:0] i_r1_chaddress,
    input  logic [IREG_WDADDR_WIDTH-1:0] i_r1_wdaddress,
    input  logic [IREG_DATA_WIDTH-1:0]   i_r1_writedata,
    input  logic                         i_r1_rwn,
    output logic                         o_r1_done,
    output logic [IREG_DATA_WIDTH-1:0]   o_r1_readdata,

    output logic                         o_ir_trigger,
    output logic [IREG_CHADDR_WIDTH-1:0] o_ir_chaddress,
    output logic [IREG_WDADDR_WIDTH-1:0] o_ir_wdaddress,
    output logic [IREG_DATA_WIDTH-1:0]   o_ir_writedata,
    output logic                         o_ir_rwn,
    input  logic                         i_ir_done,
    input  logic [IREG_DATA_WIDTH-1:0]   i_ir_readdata,

    output logic [1:0]                   o_grant,
    output logic                         o_busy,
    output logic                         o_timeout,
    input  logic                         i_clr_timeout,
    output logic [1:0]                   o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // A zero TIMEOUT_CYCLES turns the watchdog off entirely.
    localparam bit                 WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    state_t                         state_q,      state_d;
    logic                           last_grant_q, last_grant_d;   // index of last winner
    logic [1:0]                     grant_q,      grant_d;
    logic                           trigger_q,    trigger_d;
    logic                           busy_q,       busy_d;
    logic [1:0]                     done_q,       done_d;
    logic [IREG_DATA_WIDTH-1:0]     rdata0_q,     rdata0_d;
    logic [IREG_DATA_WIDTH-1:0]     rdata1_q,     rdata1_d;
    logic [IREG_CHADDR_WIDTH-1:0]   ir_ch_q,      ir_ch_d;
    logic [IREG_WDADDR_WIDTH-1:0]   ir_wd_q,      ir_wd_d;
    logic [IREG_DATA_WIDTH-1:0]     ir_wdata_q,   ir_wdata_d;
    logic                           ir_rwn_q,     ir_rwn_d;
    logic                           timeout_q,    timeout_d;
    logic [TIMEOUT_W-1:0]           wd_cnt_q,     wd_cnt_d;

    logic                           pick_r1;
    logic                           wd_set;
    logic [TIMEOUT_W-1:0]           wd_next;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        trigger_d    = 1'b0;
        done_d       = 2'b00;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ir_ch_d      = ir_ch_q;
        ir_wd_d      = ir_wd_q;
        ir_wdata_d   = ir_wdata_q;
        ir_rwn_d     = ir_rwn_q;
        wd_cnt_d     = wd_cnt_q;
        pick_r1      = 1'b0;
        wd_set       = 1'b0;
        wd_next      = wd_cnt_q + TIMEOUT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (i_r0_req || i_r1_req) begin
                    // r1 wins when it is alone, or on a tie when r0 won last.
                    pick_r1      = i_r1_req && (!i_r0_req || !last_grant_q);
                    last_grant_d = pick_r1;
                    grant_d      = pick_r1 ? 2'b10 : 2'b01;
                    ir_ch_d      = pick_r1 ? i_r1_chaddress : i_r0_chaddress;
                    ir_wd_d      = pick_r1 ? i_r1_wdaddress : i_r0_wdaddress;
                    ir_wdata_d   = pick_r1 ? i_r1_writedata : i_r0_writedata;
                    ir_rwn_d     = pick_r1 ? i_r1_rwn       : i_r0_rwn;
                    trigger_d    = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                wd_cnt_d = '0;
                state_d  = ST_WAIT;
            end

            ST_WAIT: begin
                // Saturating count; the flag fires only on the step that
                // reaches the limit so a clear while still stuck sticks.
                if (WD_EN && (wd_cnt_q != WD_LIMIT)) begin
                    wd_cnt_d = wd_next;
                    wd_set   = (wd_next == WD_LIMIT);
                end
                if (i_ir_done) begin
                    if (ir_rwn_q) begin
                        if (grant_q[1]) rdata1_d = i_ir_readdata;
                        else            rdata0_d = i_ir_readdata;
                    end
                    done_d  = grant_q;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end

            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        // Set has priority over a simultaneous clear.
        timeout_d = timeout_q;
        if (i_clr_timeout) timeout_d = 1'b0;
        if (wd_set)        timeout_d = 1'b1;
    end

    always_ff @(posedge i_avmm_clk) begin
        if (!i_resetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
            trigger_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ir_ch_q      <= '0;
            ir_wd_q      <= '0;
            ir_wdata_q   <= '0;
            ir_rwn_q     <= 1'b0;
            timeout_q    <= 1'b0;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            trigger_q    <= trigger_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ir_ch_q      <= ir_ch_d;
            ir_wd_q      <= ir_wd_d;
            ir_wdata_q   <= ir_wdata_d;
            ir_rwn_q     <= ir_rwn_d;
            timeout_q    <= timeout_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    assign o_r0_done      = done_q[0];
    assign o_r1_done      = done_q[1];
    assign o_r0_readdata  = rdata0_q;
    assign o_r1_readdata  = rdata1_q;
    assign o_ir_trigger   = trigger_q;
    assign o_ir_chaddress = ir_ch_q;
    assign o_ir_wdaddress = ir_wd_q;
    assign o_ir_writedata = ir_wdata_q;
    assign o_ir_rwn       = ir_rwn_q;
    assign o_grant        = grant_q;
    assign o_busy         = busy_q;
    assign o_timeout      = timeout_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_alt_eyemon_ir_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alt_eyemon_ir_arbiter
//
// Cycle-by-cycle vector table for the normal flows (single read, tie
// alternation, stale done in ISSUE/IDLE, re-grant, write), followed by
// hand-written watchdog and mid-transaction reset sequences.
// ---------------------------------------------------------------------------
module tb_alt_eyemon_ir_arbiter;

    localparam logic [15:0] R0_CH    = 16'h0002;
    localparam logic [15:0] R0_WD    = 16'h0001;
    localparam logic [15:0] R0_WDATA = 16'h1234;
    localparam logic [15:0] R1_CH    = 16'h0005;
    localparam logic [15:0] R1_WD    = 16'h0000;
    localparam logic [15:0] R1_WDATA = 16'h0001;
    localparam int          N_VEC    = 25;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        resetn;
    always #5 clk = ~clk;

    logic        r0_req, r0_rwn, r1_req, r1_rwn;
    logic [15:0] r0_ch, r0_wd, r0_wdata, r1_ch, r1_wd, r1_wdata;
    logic        r0_done, r1_done;
    logic [15:0] r0_rdata, r1_rdata;
    logic        ir_trig, ir_rwn, ir_done, clr_to;
    logic [15:0] ir_ch, ir_wd, ir_wdata, ir_rdata;
    logic [1:0]  grant, state;
    logic        busy, timeout;

    alt_eyemon_ir_arbiter #(
        .IREG_CHADDR_WIDTH (16),
        .IREG_WDADDR_WIDTH (16),
        .IREG_DATA_WIDTH   (16),
        .TIMEOUT_CYCLES    (8),
        .TIMEOUT_W         (11)
    ) dut (
        .i_avmm_clk     (clk),
        .i_resetn       (resetn),
        .i_r0_req       (r0_req),
        .i_r0_chaddress (r0_ch),
        .i_r0_wdaddress (r0_wd),
        .i_r0_writedata (r0_wdata),
        .i_r0_rwn       (r0_rwn),
        .o_r0_done      (r0_done),
        .o_r0_readdata  (r0_rdata),
        .i_r1_req       (r1_req),
        .i_r1_chaddress (r1_ch),
        .i_r1_wdaddress (r1_wd),
        .i_r1_writedata (r1_wdata),
        .i_r1_rwn       (r1_rwn),
        .o_r1_done      (r1_done),
        .o_r1_readdata  (r1_rdata),
        .o_ir_trigger   (ir_trig),
        .o_ir_chaddress (ir_ch),
        .o_ir_wdaddress (ir_wd),
        .o_ir_writedata (ir_wdata),
        .o_ir_rwn       (ir_rwn),
        .i_ir_done      (ir_done),
        .i_ir_readdata  (ir_rdata),
        .o_grant        (grant),
        .o_busy         (busy),
        .o_timeout      (timeout),
        .i_clr_timeout  (clr_to),
        .o_state        (state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " trig"},    32'(ir_trig),  32'd0);
        chk({tag, " grant"},   32'(grant),    32'd0);
        chk({tag, " busy"},    32'(busy),     32'd0);
        chk({tag, " done0"},   32'(r0_done),  32'd0);
        chk({tag, " done1"},   32'(r1_done),  32'd0);
        chk({tag, " rdata0"},  32'(r0_rdata), 32'd0);
        chk({tag, " rdata1"},  32'(r1_rdata), 32'd0);
        chk({tag, " ir_ch"},   32'(ir_ch),    32'd0);
        chk({tag, " ir_wd"},   32'(ir_wd),    32'd0);
        chk({tag, " ir_wdat"}, 32'(ir_wdata), 32'd0);
        chk({tag, " ir_rwn"},  32'(ir_rwn),   32'd0);
        chk({tag, " timeout"}, 32'(timeout),  32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  req;     // {r1, r0}
        logic [1:0]  rwn;     // {r1, r0}
        logic        ird;
        logic [15:0] irdata;
        logic        e_trig;
        logic [1:0]  e_grant;
        logic        e_busy;
        logic [1:0]  e_done;  // {r1, r0}
        logic [15:0] e_rd0;
        logic [15:0] e_rd1;
        int          e_src;   // whose fields sit on o_ir_*
        logic        e_rwn;
    } vec_t;

    vec_t tbl[N_VEC];

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] rwn,
                                input logic ird, input logic [15:0] irdata,
                                input logic t, input logic [1:0] g, input logic b,
                                input logic [1:0] d, input logic [15:0] rd0,
                                input logic [15:0] rd1, input int src, input logic erwn);
        vec_t v;
        v.req = req; v.rwn = rwn; v.ird = ird; v.irdata = irdata;
        v.e_trig = t; v.e_grant = g; v.e_busy = b; v.e_done = d;
        v.e_rd0 = rd0; v.e_rd1 = rd1; v.e_src = src; v.e_rwn = erwn;
        return v;
    endfunction

    initial begin
        resetn   = 1'b0;
        r0_req   = 1'b0; r1_req = 1'b0;
        r0_rwn   = 1'b1; r1_rwn = 1'b1;
        r0_ch    = R0_CH; r0_wd = R0_WD; r0_wdata = R0_WDATA;
        r1_ch    = R1_CH; r1_wd = R1_WD; r1_wdata = R1_WDATA;
        ir_done  = 1'b0; ir_rdata = 16'h0000; clr_to = 1'b0;

        //               req   rwn   ird irdata    trig grant busy done  rd0       rd1      src rwn
        // r0 read, done on the third WAIT cycle
        tbl[0]  = mk(2'b01, 2'b11, 0, 16'h0000, 1, 2'b01, 1, 2'b00, 16'h0000, 16'h0000, 0, 1);
        tbl[1]  = mk(2'b01, 2'b11, 0, 16'h0000, 0, 2'b01, 1, 2'b00, 16'h0000, 16'h0000, 0, 1);
        tbl[2]  = mk(2'b01, 2'b11, 0, 16'h0000, 0, 2'b01, 1, 2'b00, 16'h0000, 16'h0000, 0, 1);
        tbl[3]  = mk(2'b01, 2'b11, 0, 16'h0000, 0, 2'b01, 1, 2'b00, 16'h0000, 16'h0000, 0, 1);
        tbl[4]  = mk(2'b01, 2'b11, 1, 16'h002A, 0, 2'b01, 1, 2'b01, 16'h002A, 16'h0000, 0, 1);
        tbl[5]  = mk(2'b00, 2'b11, 0, 16'h0000, 0, 2'b00, 0, 2'b00, 16'h002A, 16'h0000, 0, 1);
        // spurious done while idle
        tbl[6]  = mk(2'b00, 2'b11, 1, 16'hFFFF, 0, 2'b00, 0, 2'b00, 16'h002A, 16'h0000, 0, 1);
        // tie after r0 won: r1 first, done in ISSUE ignored
        tbl[7]  = mk(2'b11, 2'b11, 0, 16'h0000, 1, 2'b10, 1, 2'b00, 16'h002A, 16'h0000, 1, 1);
        tbl[8]  = mk(2'b11, 2'b11, 1, 16'hBEEF, 0, 2'b10, 1, 2'b00, 16'h002A, 16'h0000, 1, 1);
        tbl[9]  = mk(2'b11, 2'b11, 1, 16'h0202, 0, 2'b10, 1, 2'b10, 16'h002A, 16'h0202, 1, 1);
        tbl[10] = mk(2'b11, 2'b11, 0, 16'h0000, 0, 2'b00, 0, 2'b00, 16'h002A, 16'h0202, 1, 1);
        tbl[11] = mk(2'b11, 2'b11, 0, 16'h0000, 1, 2'b01, 1, 2'b00, 16'h002A, 16'h0202, 0, 1);
        tbl[12] = mk(2'b11, 2'b11, 0, 16'h0000, 0, 2'b01, 1, 2'b00, 16'h002A, 16'h0202, 0, 1);
        tbl[13] = mk(2'b11, 2'b11, 1, 16'h0101, 0, 2'b01, 1, 2'b01, 16'h0101, 16'h0202, 0, 1);
        tbl[14] = mk(2'b11, 2'b11, 0, 16'h0000, 0, 2'b00, 0, 2'b00, 16'h0101, 16'h0202, 0, 1);
        tbl[15] = mk(2'b11, 2'b11, 0, 16'h0000, 1, 2'b10, 1, 2'b00, 16'h0101, 16'h0202, 1, 1);
        tbl[16] = mk(2'b11, 2'b11, 0, 16'h0000, 0, 2'b10, 1, 2'b00, 16'h0101, 16'h0202, 1, 1);
        tbl[17] = mk(2'b10, 2'b11, 1, 16'h0303, 0, 2'b10, 1, 2'b10, 16'h0101, 16'h0303, 1, 1);
        // r1 keeps requesting -> re-granted, now as a write
        tbl[18] = mk(2'b10, 2'b01, 0, 16'h0000, 0, 2'b00, 0, 2'b00, 16'h0101, 16'h0303, 1, 1);
        tbl[19] = mk(2'b10, 2'b01, 0, 16'h0000, 1, 2'b10, 1, 2'b00, 16'h0101, 16'h0303, 1, 0);
        tbl[20] = mk(2'b10, 2'b01, 0, 16'h0000, 0, 2'b10, 1, 2'b00, 16'h0101, 16'h0303, 1, 0);
        tbl[21] = mk(2'b10, 2'b01, 0, 16'h0000, 0, 2'b10, 1, 2'b00, 16'h0101, 16'h0303, 1, 0);
        tbl[22] = mk(2'b10, 2'b01, 1, 16'h7777, 0, 2'b10, 1, 2'b10, 16'h0101, 16'h0303, 1, 0);
        tbl[23] = mk(2'b00, 2'b01, 0, 16'h0000, 0, 2'b00, 0, 2'b00, 16'h0101, 16'h0303, 1, 0);
        tbl[24] = mk(2'b00, 2'b01, 0, 16'h0000, 0, 2'b00, 0, 2'b00, 16'h0101, 16'h0303, 1, 0);

        // ---------------- reset state ----------------
        step();
        step();
        chk_all_zero("reset");
        resetn = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < N_VEC; i++) begin
            string tag;
            logic [15:0] e_ch, e_wd, e_wdat;
            tag    = $sformatf("row%0d", i);
            e_ch   = (tbl[i].e_src == 1) ? R1_CH    : R0_CH;
            e_wd   = (tbl[i].e_src == 1) ? R1_WD    : R0_WD;
            e_wdat = (tbl[i].e_src == 1) ? R1_WDATA : R0_WDATA;
            r0_req   = tbl[i].req[0];
            r1_req   = tbl[i].req[1];
            r0_rwn   = tbl[i].rwn[0];
            r1_rwn   = tbl[i].rwn[1];
            ir_done  = tbl[i].ird;
            ir_rdata = tbl[i].irdata;
            step();
            chk({tag, " trig"},    32'(ir_trig),  32'(tbl[i].e_trig));
            chk({tag, " grant"},   32'(grant),    32'(tbl[i].e_grant));
            chk({tag, " busy"},    32'(busy),     32'(tbl[i].e_busy));
            chk({tag, " done0"},   32'(r0_done),  32'(tbl[i].e_done[0]));
            chk({tag, " done1"},   32'(r1_done),  32'(tbl[i].e_done[1]));
            chk({tag, " rdata0"},  32'(r0_rdata), 32'(tbl[i].e_rd0));
            chk({tag, " rdata1"},  32'(r1_rdata), 32'(tbl[i].e_rd1));
            chk({tag, " ir_ch"},   32'(ir_ch),    32'(e_ch));
            chk({tag, " ir_wd"},   32'(ir_wd),    32'(e_wd));
            chk({tag, " ir_wdat"}, 32'(ir_wdata), 32'(e_wdat));
            chk({tag, " ir_rwn"},  32'(ir_rwn),   32'(tbl[i].e_rwn));
            chk({tag, " timeout"}, 32'(timeout),  32'd0);
        end

        // ---------------- watchdog: master never answers ----------------
        r0_rwn = 1'b1; r1_rwn = 1'b1;
        ir_done = 1'b0;
        r0_req = 1'b1;
        step();
        chk("wd trig", 32'(ir_trig), 32'd1);
        r0_req = 1'b1;
        step();                                  // now in WAIT, count cleared
        for (int k = 1; k <= 7; k++) step();     // seven WAIT cycles
        chk("wd to before limit", 32'(timeout), 32'd0);
        step();                                  // eighth WAIT cycle
        chk("wd to at limit", 32'(timeout), 32'd1);
        chk("wd busy at limit", 32'(busy), 32'd1);
        step();
        step();
        chk("wd to sticky", 32'(timeout), 32'd1);
        chk("wd busy waiting", 32'(busy), 32'd1);
        chk("wd no done", 32'(r0_done), 32'd0);
        ir_done = 1'b1; ir_rdata = 16'h0BAD;
        step();
        chk("wd late done0", 32'(r0_done), 32'd1);
        chk("wd late rdata0", 32'(r0_rdata), 32'h0BAD);
        ir_done = 1'b0; r0_req = 1'b0;
        step();
        chk("wd idle busy", 32'(busy), 32'd0);
        chk("wd idle to", 32'(timeout), 32'd1);
        clr_to = 1'b1;
        step();
        clr_to = 1'b0;
        chk("wd cleared", 32'(timeout), 32'd0);

        // ---------------- reset during WAIT ----------------
        r0_req = 1'b1;                           // r0 wins, so without reset a tie would go to r1
        step();
        chk("rst grant r0", 32'(grant), 32'b01);
        step();                                  // WAIT
        resetn = 1'b0; ir_done = 1'b1; ir_rdata = 16'h1111;
        step();
        chk_all_zero("rst mid");
        resetn = 1'b1; ir_done = 1'b0;
        r0_req = 1'b1; r1_req = 1'b1;
        step();
        chk("rst tie grant", 32'(grant), 32'b01);
        chk("rst tie trig", 32'(ir_trig), 32'd1);
        // requester-side changes after grant must not reach o_ir_*
        r0_ch = 16'h00EE; r0_wdata = 16'hCAFE;
        step();
        chk("hold ir_ch", 32'(ir_ch), 32'(R0_CH));
        chk("hold ir_wdat", 32'(ir_wdata), 32'(R0_WDATA));
        ir_done = 1'b1; ir_rdata = 16'h4444;
        step();
        chk("rst r0 done", 32'(r0_done), 32'd1);
        chk("rst r0 rdata", 32'(r0_rdata), 32'h4444);
        chk("rst r1 nodone", 32'(r1_done), 32'd0);
        ir_done = 1'b0; r0_req = 1'b0;
        r0_ch = R0_CH; r0_wdata = R0_WDATA;
        step();
        step();
        chk("rst then r1 grant", 32'(grant), 32'b10);
        chk("rst then r1 ch", 32'(ir_ch), 32'(R1_CH));
        step();
        ir_done = 1'b1; ir_rdata = 16'h5555;
        step();
        chk("rst r1 done", 32'(r1_done), 32'd1);
        chk("rst r1 rdata", 32'(r1_rdata), 32'h5555);
        ir_done = 1'b0; r1_req = 1'b0;
        step();
        chk("end idle busy", 32'(busy), 32'd0);
        chk("end idle grant", 32'(grant), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
